ps2_key_serializer: RTL

//  Transmit end of the keyboard path. Takes the hps_io ps2_key event word (toggle/pressed/extended/scancode).
//  Re-encodes each event as PS/2 set-2 device bytes (E0 / F0 prefixes, then the scancode) and drives them as
//  PS/2 device clock/data frames into the pc8001m ps2_clk/ps2_data inputs. A byte FIFO decouples event bursts

---
 rtl/ps2_key_serializer.sv | 112 +++++++++++
 1 files changed

// File: rtl/ps2_key_serializer.sv
// ps2_key_serializer: re-encodes hps_io key events as PS/2 set-2 bytes, buffers them and clocks them out as device frames
module ps2_key_serializer #(
  parameter int CLK_HALF = 1000,
  parameter int GAP      = 2000,
  parameter int FIFO_AW  = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  output logic        ps2_clk,
  output logic        ps2_data,
  output logic        busy,
  output logic        overflow
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int MX    = CLK_HALF > GAP ? CLK_HALF : GAP;
  localparam int CW    = $clog2(MX + 1);
  localparam logic [CW-1:0] HALF_LD = CW'(CLK_HALF - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP - 1);
  typedef enum logic [1:0] {IDLE, BIT_HI, BIT_LO, GAP_ST} state_t;
  logic [10:0]      r_k;
  logic             r_tog, r_seq, r_e_p, r_f_p;
  logic [7:0]       r_code;
  logic [7:0]       r_mem [DEPTH];
  logic [FIFO_AW:0] r_wp, r_rp;
  state_t           r_st;
  logic [CW-1:0]    r_cnt;
  logic [9:0]       r_sh;
  logic [3:0]       r_bit;
  logic [FIFO_AW:0] w_used, w_free;
  logic [1:0]       w_n;
  logic             w_ev, w_fit, w_empty, w_load;
  logic [7:0]       w_wbyte, w_rbyte;
  assign w_used   = r_wp - r_rp;
  assign w_free   = (FIFO_AW+1)'(DEPTH) - w_used;
  assign w_n      = 2'd1 + {1'b0, r_k[8]} + {1'b0, ~r_k[9]};
  assign w_ev     = (r_k[10] != r_tog) && !r_seq;
  assign w_fit    = w_free >= (FIFO_AW+1)'(w_n);
  assign w_empty  = r_wp == r_rp;
  assign w_wbyte  = r_e_p ? 8'hE0 : r_f_p ? 8'hF0 : r_code;
  assign w_rbyte  = r_mem[r_rp[FIFO_AW-1:0]];
  // a frame may start straight out of the gap so consecutive frames are separated by exactly GAP cycles
  assign w_load   = !w_empty && (r_st == IDLE || (r_st == GAP_ST && r_cnt == '0));
  assign busy     = r_st != IDLE || !w_empty || r_seq;
  always_ff @(posedge clk_sys)
    if (r_seq) r_mem[r_wp[FIFO_AW-1:0]] <= w_wbyte;
  always_ff @(posedge clk_sys) begin
    r_k <= ps2_key;
    if (reset) begin
      r_tog    <= ps2_key[10];
      r_seq    <= 1'b0;
      r_e_p    <= 1'b0;
      r_f_p    <= 1'b0;
      r_code   <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_st     <= IDLE;
      r_cnt    <= '0;
      r_sh     <= '0;
      r_bit    <= '0;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      overflow <= 1'b0;
    end else begin
      overflow <= w_ev && !w_fit;
      if (w_ev) begin
        r_tog <= r_k[10];
        if (w_fit) begin
          r_seq  <= 1'b1;
          r_e_p  <= r_k[8];
          r_f_p  <= ~r_k[9];
          r_code <= r_k[7:0];
        end
      end
      if (r_seq) begin
        r_wp <= r_wp + 1'b1;
        if (r_e_p) r_e_p <= 1'b0;
        else if (r_f_p) r_f_p <= 1'b0;
        else r_seq <= 1'b0;
      end
      if (w_load) begin
        r_rp     <= r_rp + 1'b1;
        r_st     <= BIT_HI;
        r_cnt    <= HALF_LD;
        r_sh     <= {1'b1, ~^w_rbyte, w_rbyte};
        r_bit    <= '0;
        ps2_clk  <= 1'b1;
        ps2_data <= 1'b0;
      end else if (r_st != IDLE && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end else begin
        case (r_st)
          BIT_HI: begin
            r_st    <= BIT_LO;
            r_cnt   <= HALF_LD;
            ps2_clk <= 1'b0;
          end
          BIT_LO: begin
            ps2_clk  <= 1'b1;
            r_bit    <= r_bit + 1'b1;
            r_sh     <= r_sh >> 1;
            ps2_data <= r_bit == 4'd10 ? 1'b1 : r_sh[0];
            r_st     <= r_bit == 4'd10 ? GAP_ST : BIT_HI;
            r_cnt    <= r_bit == 4'd10 ? GAP_LD : HALF_LD;
          end
          GAP_ST:  r_st <= IDLE;
          default: r_st <= IDLE;
        endcase
      end
    end
  end
endmodule
